// File: rtl/mips_arb_pkg.sv
// mips_arb_pkg: shared types and constants for the MIPS memory arbiter
package mips_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_t;
  typedef enum logic {INSTR, DATA} owner_t;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;
  localparam int TIMEOUT_W = 10;
endpackage

// File: rtl/arb_timeout_counter.sv
// arb_timeout_counter: counts stalled bus cycles, flags the LIMIT-th stalled edge
module arb_timeout_counter
  import mips_arb_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(LIMIT - 1);
  logic [TIMEOUT_W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && cnt != LAST) cnt <= cnt + 1'b1;
  // asserted on the stalled cycle whose edge would be the LIMIT-th stall
  assign expired = enable && cnt == LAST;
endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: round-robin arbiter of fetch and load/store ports onto one bus
module mips_mem_arbiter
  import mips_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_read,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        instr_ack,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [3:0]  data_byteenable,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        data_ack,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        bus_error
);
  state_t state, state_next;
  owner_t last_owner;
  logic grant_d, grant_i, grant, in_bus, done, expired;
  always_comb begin
    grant_d = (data_read || data_write) && (!instr_read || last_owner == INSTR);
    grant_i = instr_read && !grant_d;
    grant = state == IDLE && (grant_i || grant_d);
    in_bus = state == BUS_I || state == BUS_D;
    done = in_bus && !mem_waitrequest;
    state_next = state == IDLE ? (grant_d ? BUS_D : grant_i ? BUS_I : IDLE) :
                 state == RESP ? IDLE :
                 (done || expired) ? RESP : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      last_owner <= INSTR;
    end else begin
      state <= state_next;
      if (grant) last_owner <= grant_d ? DATA : INSTR;
    end
  arb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .reset(reset),
    .clear(grant),
    .enable(in_bus && mem_waitrequest),
    .expired(expired)
  );
  // read/write with both strobes set is a store
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem_address <= '0;
      mem_writedata <= '0;
      mem_byteenable <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      instr_readdata <= '0;
      data_readdata <= '0;
      instr_ack <= 1'b0;
      data_ack <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      instr_ack <= 1'b0;
      data_ack <= 1'b0;
      bus_error <= 1'b0;
      if (grant) begin
        mem_address <= grant_d ? data_address : instr_address;
        mem_byteenable <= grant_d ? data_byteenable : 4'hF;
        mem_writedata <= grant_d ? data_writedata : '0;
        mem_read <= grant_i || !data_write;
        mem_write <= grant_d && data_write;
      end else if (done || expired) begin
        mem_read <= 1'b0;
        mem_write <= 1'b0;
        instr_ack <= state == BUS_I;
        data_ack <= state == BUS_D;
        bus_error <= expired;
        instr_readdata <= state == BUS_I ? (done && mem_read ? mem_readdata : '0) : instr_readdata;
        data_readdata <= state == BUS_D ? (done && mem_read ? mem_readdata : '0) : data_readdata;
      end
    end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed and randomized checks against a transaction-level requester model
module tb_mips_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, instr_read, data_read, data_write, mem_waitrequest, t_wait;
  logic [31:0] instr_address, data_address, data_writedata, mem_readdata;
  logic [3:0] data_byteenable;
  logic [31:0] instr_readdata, data_readdata, mem_address, mem_writedata;
  logic [3:0] mem_byteenable;
  logic instr_ack, data_ack, mem_read, mem_write, bus_error;
  logic [31:0] t_instr_readdata, t_data_readdata, t_mem_address, t_mem_writedata;
  logic [3:0] t_mem_byteenable;
  logic t_instr_ack, t_data_ack, t_mem_read, t_mem_write, t_bus_error;
  int checks = 0, errors = 0;
  bit last_data;

  mips_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .instr_read(instr_read), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .instr_ack(instr_ack),
    .data_read(data_read), .data_write(data_write), .data_address(data_address),
    .data_byteenable(data_byteenable), .data_writedata(data_writedata),
    .data_readdata(data_readdata), .data_ack(data_ack),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_read(mem_read), .mem_write(mem_write),
    .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest), .bus_error(bus_error)
  );

  mips_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset),
    .instr_read(instr_read), .instr_address(instr_address),
    .instr_readdata(t_instr_readdata), .instr_ack(t_instr_ack),
    .data_read(data_read), .data_write(data_write), .data_address(data_address),
    .data_byteenable(data_byteenable), .data_writedata(data_writedata),
    .data_readdata(t_data_readdata), .data_ack(t_data_ack),
    .mem_address(t_mem_address), .mem_writedata(t_mem_writedata),
    .mem_byteenable(t_mem_byteenable), .mem_read(t_mem_read), .mem_write(t_mem_write),
    .mem_readdata(mem_readdata), .mem_waitrequest(t_wait), .bus_error(t_bus_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Serve one transfer starting from an IDLE cycle with the owner's request already driven
  task automatic serve(input bit who_data, input int stall, input bit early);
    logic [31:0] ea, ew, rd;
    logic [3:0] eb;
    bit wr;
    wr = who_data && data_write;
    ea = who_data ? data_address : instr_address;
    eb = who_data ? data_byteenable : 4'hF;
    ew = data_writedata;
    rd = '0;
    tick;
    if (early) begin
      if (who_data) {data_read, data_write} = 2'b00;
      else instr_read = 1'b0;
    end
    for (int s = stall; s >= 0; s--) begin
      chk("mem_read", 32'(mem_read), 32'(!wr));
      chk("mem_write", 32'(mem_write), 32'(wr));
      chk("mem_address", mem_address, ea);
      chk("mem_byteenable", 32'(mem_byteenable), 32'(eb));
      if (wr) chk("mem_writedata", mem_writedata, ew);
      chk("ack_during_bus", 32'({instr_ack, data_ack}), 0);
      mem_waitrequest = s > 0;
      mem_readdata = $urandom;
      rd = mem_readdata;
      tick;
    end
    mem_waitrequest = 1'b0;
    chk("instr_ack", 32'(instr_ack), 32'(!who_data));
    chk("data_ack", 32'(data_ack), 32'(who_data));
    chk(who_data ? "data_readdata" : "instr_readdata", who_data ? data_readdata : instr_readdata, wr ? 32'd0 : rd);
    chk("bus_error", 32'(bus_error), 0);
    chk("strobes_in_resp", 32'({mem_read, mem_write}), 0);
    if (who_data) {data_read, data_write} = 2'b00;
    else instr_read = 1'b0;
    last_data = who_data;
    tick;
    chk("ack_one_cycle", 32'({instr_ack, data_ack}), 0);
  endtask

  // Round robin: with both pending, the side not granted last goes first
  task automatic arbitrate(input bit ir, input bit dr, input int st_a, input int st_b, input bit early);
    bit first;
    if (ir && dr) begin
      first = !last_data;
      serve(first, st_a, early);
      serve(!first, st_b, 1'b0);
    end else serve(dr, st_a, early);
  endtask

  initial begin
    int k, op;
    bit ir, dr;
    reset = 1'b0;
    {instr_read, data_read, data_write, mem_waitrequest, t_wait} = '0;
    {instr_address, data_address, data_writedata, mem_readdata} = '0;
    data_byteenable = '0;
    tick; tick;
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_writedata", mem_writedata, 0);
    chk("rst_strobes", 32'({mem_read, mem_write, mem_byteenable}), 0);
    chk("rst_readdata", instr_readdata | data_readdata, 0);
    chk("rst_acks_err", 32'({instr_ack, data_ack, bus_error}), 0);
    reset = 1'b1;
    last_data = 1'b0;
    tick;
    // first conflict after reset goes to data
    instr_read = 1'b1; instr_address = 32'h0040_0000;
    data_write = 1'b1; data_address = 32'h100; data_writedata = 32'hDEADBEEF; data_byteenable = 4'b0011;
    serve(1'b1, 0, 1'b0);
    // data requester re-raises immediately: data was granted last, so instr wins
    data_read = 1'b1; data_address = 32'h200; data_byteenable = 4'hF;
    arbitrate(1'b1, 1'b1, 0, 0, 1'b0);
    instr_read = 1'b1; instr_address = 32'hBFC0_0000;
    serve(1'b0, 0, 1'b0);
    data_read = 1'b1; data_address = 32'h1000_0040; data_byteenable = 4'hF;
    serve(1'b1, 5, 1'b0);
    // reset in the middle of a store
    data_write = 1'b1; data_address = 32'h300; data_writedata = 32'h0BAD_F00D;
    tick;
    chk("mid_write_on", 32'(mem_write), 1);
    reset = 1'b0;
    #1;
    chk("async_write_drop", 32'(mem_write), 0);
    chk("async_addr_clear", mem_address, 0);
    data_write = 1'b0;
    tick;
    chk("no_ack_in_reset", 32'({instr_ack, data_ack}), 0);
    reset = 1'b1;
    last_data = 1'b0;
    tick;
    chk("no_ack_after_reset", 32'({instr_ack, data_ack, mem_write}), 0);
    instr_read = 1'b1; instr_address = 32'hBFC0_0004;
    serve(1'b0, 0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(1, 3);
      ir = k[0]; dr = k[1];
      op = $urandom_range(0, 2);
      instr_address = $urandom; data_address = $urandom;
      data_writedata = $urandom; data_byteenable = 4'($urandom);
      instr_read = ir;
      data_read = dr && op != 1;
      data_write = dr && op != 0;
      arbitrate(ir, dr, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        chk("idle_strobes", 32'({mem_read, mem_write, instr_ack, data_ack}), 0);
        tick;
      end
    end
    // timeout instance: resynchronise with a reset pulse first
    reset = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    data_read = 1'b1; data_address = 32'h440; data_byteenable = 4'hF;
    t_wait = 1'b1;
    tick;
    for (int c = 0; c < 3; c++) begin
      chk("to3_strobe", 32'(t_mem_read), 1);
      chk("to3_noack", 32'(t_data_ack), 0);
      tick;
    end
    t_wait = 1'b0;
    mem_readdata = 32'h1234_5678;
    chk("to3_strobe_last", 32'(t_mem_read), 1);
    tick;
    chk("to3_ack", 32'(t_data_ack), 1);
    chk("to3_no_error", 32'(t_bus_error), 0);
    chk("to3_readdata", t_data_readdata, 32'h1234_5678);
    data_read = 1'b0;
    t_wait = 1'b1;
    tick;
    data_read = 1'b1;
    tick;
    for (int c = 0; c < 4; c++) begin
      chk("to4_strobe", 32'(t_mem_read), 1);
      chk("to4_noack", 32'(t_data_ack), 0);
      tick;
    end
    chk("to4_strobe_drop", 32'(t_mem_read), 0);
    chk("to4_ack", 32'(t_data_ack), 1);
    chk("to4_readdata", t_data_readdata, 0);
    chk("to4_bus_error", 32'(t_bus_error), 1);
    data_read = 1'b0;
    tick;
    chk("to4_pulse_end", 32'({t_data_ack, t_bus_error}), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
